// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and constants for the register-file controller.
// Optional feature macro: RFC_DUMP_EN (builds the host DUMP burst path).
package reg_file_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } rfc_state_t;

    // Host command opcodes carried on cmd_op.
    localparam logic kRFC_LOAD = 1'b0;
    localparam logic kRFC_DUMP = 1'b1;

endpackage

// File: rtl/rfc_burst_counter.sv
// Burst address/length tracker: loads base and length on command accept,
// advances one register per accepted beat and flags the final beat.
// Optional feature macro: RFC_DUMP_EN (not referenced here).
module rfc_burst_counter #(
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [D-1:0] base,
    input  logic [D-1:0] len,
    output logic [D-1:0] ptr,
    output logic         last
);

    // Remaining beats; one extra bit so a zero length means the full 2**D.
    logic [D:0] rem;

    // Load pointer/count on accept, otherwise advance on each beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            rem <= '0;
        end else if (load) begin
            ptr <= base;
            rem <= (len == '0) ? {1'b1, {D{1'b0}}} : {1'b0, len};
        end else if (step) begin
            ptr <= ptr + 1'b1;
            rem <= rem - 1'b1;
        end
    end

    assign last = (rem == {{D{1'b0}}, 1'b1});

endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file write/read port arbiter between core writeback and the host
// LOAD/DUMP burst channel. The core is stalled while a host burst runs.
// Optional feature macro: RFC_DUMP_EN (when undefined, DUMP commands are
// accepted but answered with a one-cycle cmd_err pulse).
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         core_we,
    input  logic [D-1:0] core_waddr,
    input  logic [W-1:0] core_wdata,
    input  logic [D-1:0] core_raddr,
    output logic         core_stall,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [D-1:0] cmd_base,
    input  logic [D-1:0] cmd_len,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [W-1:0] din_data,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [W-1:0] dout_data,
    output logic         cmd_err,
    output logic         rf_we,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_wdata,
    output logic [D-1:0] rf_raddr,
    input  logic [W-1:0] rf_rdata
);

    rfc_state_t   state;
    rfc_state_t   state_nxt;
    logic         accept;
    logic         load_beat;
    logic         dump_beat;
    logic         cnt_load;
    logic         last;
    logic [D-1:0] ptr;

    // Reset gating keeps handshake outputs low while reset is held.
    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign load_beat = (state == LOAD) && din_valid;
    assign dout_data = rf_rdata;

`ifdef RFC_DUMP_EN
    assign dump_beat = (state == DUMP) && dout_ready;
    assign cnt_load  = accept;
    assign cmd_err   = 1'b0;
`else
    logic err_q;
    logic unused_dout_ready;

    assign unused_dout_ready = dout_ready;
    assign dump_beat = 1'b0;
    assign cnt_load  = accept && (cmd_op == kRFC_LOAD);
    assign cmd_err   = err_q;

    // Flag a DUMP request for one cycle since the dump path is not built.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (cmd_op == kRFC_DUMP);
        end
    end
`endif

    rfc_burst_counter #(
        .D (D)
    ) u_burst_counter (
        .clk  (CLK),
        .rst  (reset),
        .load (cnt_load),
        .step (load_beat || dump_beat),
        .base (cmd_base),
        .len  (cmd_len),
        .ptr  (ptr),
        .last (last)
    );

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start a burst on accept, return to IDLE on the last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == kRFC_LOAD) begin
                        state_nxt = LOAD;
                    end
`ifdef RFC_DUMP_EN
                    else begin
                        state_nxt = DUMP;
                    end
`endif
                end
            end
            LOAD: begin
                if (load_beat && last) begin
                    state_nxt = IDLE;
                end
            end
`ifdef RFC_DUMP_EN
            DUMP: begin
                if (dump_beat && last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Port muxing: core owns the register file in IDLE, host owns it in bursts.
    always_comb begin
        core_stall = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = core_waddr;
        rf_wdata   = core_wdata;
        rf_raddr   = core_raddr;
        case (state)
            IDLE: begin
                rf_we = core_we && !reset;
            end
            LOAD: begin
                core_stall = 1'b1;
                din_ready  = 1'b1;
                rf_we      = din_valid;
                rf_waddr   = ptr;
                rf_wdata   = din_data;
            end
`ifdef RFC_DUMP_EN
            DUMP: begin
                core_stall = 1'b1;
                dout_valid = 1'b1;
                rf_raddr   = ptr;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed self-checking bench for reg_file_ctrl with a behavioural register
// file attached. Optional feature macro: RFC_DUMP_EN selects the DUMP checks
// or the cmd_err checks.
module tb_reg_file_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic         core_we;
    logic [D-1:0] core_waddr;
    logic [W-1:0] core_wdata;
    logic [D-1:0] core_raddr;
    logic         core_stall;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic [D-1:0] cmd_base;
    logic [D-1:0] cmd_len;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] din_data;
    logic         dout_valid;
    logic         dout_ready;
    logic [W-1:0] dout_data;
    logic         cmd_err;
    logic         rf_we;
    logic [D-1:0] rf_waddr;
    logic [W-1:0] rf_wdata;
    logic [D-1:0] rf_raddr;
    logic [W-1:0] rf_rdata;

    logic [W-1:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;
    int we_pulses;

    typedef struct {
        logic         we;
        logic [D-1:0] wa;
        logic [W-1:0] wd;
        logic [D-1:0] ra;
        logic         e_we;
        logic [D-1:0] e_wa;
        logic [W-1:0] e_wd;
        logic [D-1:0] e_ra;
    } vec_t;

    vec_t vecs [4];

    reg_file_ctrl #(
        .W (W),
        .D (D)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_raddr (core_raddr),
        .core_stall (core_stall),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .cmd_err    (cmd_err),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // Behavioural register file: synchronous write, combinational read.
    always @(posedge CLK) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = mem[rf_raddr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [W-1:0] ld_data [4];
        logic [D-1:0] ld_addr [4];

        reset      = 1'b1;
        core_we    = 1'b1;
        core_waddr = 4'd1;
        core_wdata = 8'h77;
        core_raddr = '0;
        cmd_valid  = 1'b1;
        cmd_op     = 1'b0;
        cmd_base   = '0;
        cmd_len    = '0;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = 1'b0;

        // Reset state: handshakes and writes held off even with requests active.
        #2;
        chk("rst_stall",     32'(core_stall), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready),  32'd0);
        chk("rst_din_ready", 32'(din_ready),  32'd0);
        chk("rst_dout_valid",32'(dout_valid), 32'd0);
        chk("rst_cmd_err",   32'(cmd_err),    32'd0);
        chk("rst_rf_we",     32'(rf_we),      32'd0);
        tick();
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        core_we   = 1'b0;
        #1;

        // Core passthrough table.
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd7,  1'b1, 4'd3,  8'hA5, 4'd7};
        vecs[1] = '{1'b0, 4'd9,  8'h3C, 4'd0,  1'b0, 4'd9,  8'h3C, 4'd0};
        vecs[2] = '{1'b1, 4'd0,  8'h00, 4'd15, 1'b1, 4'd0,  8'h00, 4'd15};
        vecs[3] = '{1'b1, 4'd15, 8'hFF, 4'd3,  1'b1, 4'd15, 8'hFF, 4'd3};
        for (int i = 0; i < 4; i++) begin
            core_we    = vecs[i].we;
            core_waddr = vecs[i].wa;
            core_wdata = vecs[i].wd;
            core_raddr = vecs[i].ra;
            #1;
            chk("pt_rf_we",    32'(rf_we),      32'(vecs[i].e_we));
            chk("pt_rf_waddr", 32'(rf_waddr),   32'(vecs[i].e_wa));
            chk("pt_rf_wdata", 32'(rf_wdata),   32'(vecs[i].e_wd));
            chk("pt_rf_raddr", 32'(rf_raddr),   32'(vecs[i].e_ra));
            chk("pt_stall",    32'(core_stall), 32'd0);
            chk("pt_cmd_ready",32'(cmd_ready),  32'd1);
            tick();
        end
        core_we = 1'b0;
        chk("pt_mem3", 32'(mem[3]), 32'hA5);

        // LOAD len=0 from base 7: 16 beats, wrapping through 15 -> 0 -> 6.
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_base  = 4'd7;
        cmd_len   = 4'd0;
        #1;
        chk("l16_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        din_valid = 1'b1;
        we_pulses = 0;
        for (int i = 0; i < 17; i++) begin
            din_data = 8'(8'hC0 + i);
            #1;
            if (rf_we) we_pulses++;
            if (i < 16) chk("l16_waddr", 32'(rf_waddr), 32'((7 + i) % 16));
            tick();
        end
        din_valid = 1'b0;
        #1;
        chk("l16_pulses", 32'(we_pulses),  32'd16);
        chk("l16_stall",  32'(core_stall), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("l16_mem", 32'(mem[i]), 32'(8'hC0 + ((i + 16 - 7) % 16)));
        end

        // LOAD base=14 len=4 with data gaps, core write in the accept cycle.
        ld_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        ld_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        cmd_valid  = 1'b1;
        cmd_base   = 4'd14;
        cmd_len    = 4'd4;
        core_we    = 1'b1;
        core_waddr = 4'd5;
        core_wdata = 8'h5A;
        #1;
        chk("lw_acc_rf_we", 32'(rf_we),      32'd1);
        chk("lw_acc_waddr", 32'(rf_waddr),   32'd5);
        chk("lw_acc_stall", 32'(core_stall), 32'd0);
        tick();
        cmd_valid  = 1'b0;
        core_wdata = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            din_valid = 1'b0;
            #1;
            chk("lw_gap_rf_we", 32'(rf_we),      32'd0);
            chk("lw_gap_stall", 32'(core_stall), 32'd1);
            chk("lw_din_ready", 32'(din_ready),  32'd1);
            chk("lw_cmd_ready", 32'(cmd_ready),  32'd0);
            tick();
            din_valid = 1'b1;
            din_data  = ld_data[k];
            #1;
            chk("lw_beat_we",    32'(rf_we),    32'd1);
            chk("lw_beat_waddr", 32'(rf_waddr), 32'(ld_addr[k]));
            tick();
        end
        din_valid = 1'b0;
        core_we   = 1'b0;
        #1;
        chk("lw_end_stall", 32'(core_stall), 32'd0);
        chk("lw_end_ready", 32'(cmd_ready),  32'd1);
        chk("lw_mem14", 32'(mem[14]), 32'h11);
        chk("lw_mem15", 32'(mem[15]), 32'h22);
        chk("lw_mem0",  32'(mem[0]),  32'h33);
        chk("lw_mem1",  32'(mem[1]),  32'h44);
        chk("lw_mem5",  32'(mem[5]),  32'h5A);
        chk("lw_mem2",  32'(mem[2]),  32'hCB);

`ifdef RFC_DUMP_EN
        // DUMP base=2 len=3 under backpressure: expect CB, CC, CD.
        begin
            logic [W-1:0] dexp [3];
            logic         rdy  [6];
            int           idx;
            dexp = '{8'hCB, 8'hCC, 8'hCD};
            rdy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            cmd_valid = 1'b1;
            cmd_op    = 1'b1;
            cmd_base  = 4'd2;
            cmd_len   = 4'd3;
            #1;
            chk("d_accept", 32'(cmd_ready), 32'd1);
            tick();
            cmd_valid = 1'b0;
            idx = 0;
            for (int c = 0; c < 6; c++) begin
                dout_ready = rdy[c];
                #1;
                chk("d_valid", 32'(dout_valid), 32'd1);
                chk("d_data",  32'(dout_data),  32'(dexp[idx]));
                chk("d_raddr", 32'(rf_raddr),   32'(2 + idx));
                chk("d_stall", 32'(core_stall), 32'd1);
                chk("d_rf_we", 32'(rf_we),      32'd0);
                if (rdy[c]) idx++;
                tick();
            end
            dout_ready = 1'b0;
            #1;
            chk("d_end_valid", 32'(dout_valid), 32'd0);
            chk("d_end_stall", 32'(core_stall), 32'd0);
            chk("d_cmd_err",   32'(cmd_err),    32'd0);
        end
`else
        // DUMP request without the dump path: accepted, one cmd_err pulse.
        cmd_valid  = 1'b1;
        cmd_op     = 1'b1;
        cmd_base   = 4'd2;
        cmd_len    = 4'd3;
        core_raddr = 4'd6;
        #1;
        chk("e_accept",  32'(cmd_ready), 32'd1);
        chk("e_err_pre", 32'(cmd_err),   32'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("e_err_pulse", 32'(cmd_err),    32'd1);
        chk("e_stall",     32'(core_stall), 32'd0);
        chk("e_dout_valid",32'(dout_valid), 32'd0);
        chk("e_idle_ready",32'(cmd_ready),  32'd1);
        chk("e_raddr",     32'(rf_raddr),   32'd6);
        tick();
        chk("e_err_done",  32'(cmd_err),    32'd0);
        chk("e_dout_valid2",32'(dout_valid),32'd0);
        chk("e_stall2",    32'(core_stall), 32'd0);
`endif

        // Reset mid-LOAD after two beats into registers 8 and 9.
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_base  = 4'd8;
        cmd_len   = 4'd5;
        tick();
        cmd_valid = 1'b0;
        din_valid = 1'b1;
        din_data  = 8'h31;
        #1;
        chk("r_waddr0", 32'(rf_waddr), 32'd8);
        tick();
        din_data = 8'h32;
        tick();
        din_data = 8'h33;
        #1;
        chk("r_third_we", 32'(rf_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_stall",     32'(core_stall), 32'd0);
        chk("r_din_ready", 32'(din_ready),  32'd0);
        chk("r_rf_we",     32'(rf_we),      32'd0);
        tick();
        reset     = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("r_post_stall", 32'(core_stall), 32'd0);
        chk("r_post_ready", 32'(cmd_ready),  32'd1);
        chk("r_mem8",  32'(mem[8]),  32'h31);
        chk("r_mem9",  32'(mem[9]),  32'h32);
        chk("r_mem10", 32'(mem[10]), 32'hC3);
        chk("r_mem11", 32'(mem[11]), 32'hC4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
